gray_count_tracker: RTL and testbench

GRAY_COUNT_TRACKER -- requirements
Module: gray_count_tracker

---
 rtl/gray_count_tracker.sv | 136 +++++++++++++
 tb/tb_gray_count_tracker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_count_tracker.sv
`default_nettype none
// ============================================================================
// gray_count_tracker : tracks a remote Gray-coded up/down count, reports
// its binary value and the net signed step count since the last consume.
// Revision: 1.0
// ============================================================================
module gray_count_tracker #(
  parameter int width = 10
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [width-1:0] grayIn,
  output logic [width-1:0] readBin,
  output logic             readBin__RDY,
  output logic [width-1:0] readDelta,
  output logic             readDelta__RDY,
  input  logic             consume__ENA,
  output logic             consume__RDY,
  output logic             errorMulti,
  output logic             errorOvf,
  input  logic             clearError__ENA,
  output logic             clearError__RDY
);

  typedef enum logic [1:0] {
    FILL0 = 2'd0,
    FILL1 = 2'd1,
    PRIME = 2'd2,
    TRACK = 2'd3
  } state_t;

  localparam logic [width-1:0] one_v   = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] acc_max = {1'b0, {(width-1){1'b1}}};
  localparam logic [width-1:0] acc_min = {1'b1, {(width-1){1'b0}}};

  state_t           state;
  logic [width-1:0] sync1;
  logic [width-1:0] sync2;
  logic [width-1:0] prev_gray;
  logic [width-1:0] bin_q;
  logic [width-1:0] acc;
  logic             err_multi;
  logic             err_ovf;

  logic [width-1:0] sample_bin;
  logic [width-1:0] diff;
  logic             one_bit;
  logic             multi;
  logic             step_up;
  logic [width-1:0] base;
  logic [width-1:0] acc_next;
  logic             sat;
  logic             ev_multi;
  logic             ev_ovf;

  function automatic logic [width-1:0] gray_to_bin(input logic [width-1:0] g);
    logic [width-1:0] b;
    b = '0;
    b[width-1] = g[width-1];
    for (int i = width - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // bin_q always mirrors gray_to_bin(prev_gray), so it serves as the reference
  always_comb begin
    sample_bin = gray_to_bin(sync2);
    diff       = sync2 ^ prev_gray;
    one_bit    = (diff != '0) && ((diff & (diff - one_v)) == '0);
    multi      = (diff != '0) && !one_bit;
    step_up    = (sample_bin == (bin_q + one_v));
    base       = consume__ENA ? '0 : acc;
    acc_next   = step_up ? (base + one_v) : (base - one_v);
    sat        = step_up ? (base == acc_max) : (base == acc_min);
    ev_multi   = (state == TRACK) && multi;
    ev_ovf     = (state == TRACK) && one_bit && sat;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FILL0;
      sync1     <= '0;
      sync2     <= '0;
      prev_gray <= '0;
      bin_q     <= '0;
      acc       <= '0;
      err_multi <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      sync1 <= grayIn;
      sync2 <= sync1;

      case (state)
        FILL0: state <= FILL1;
        FILL1: state <= PRIME;
        PRIME: begin
          prev_gray <= sync2;
          bin_q     <= sample_bin;
          state     <= TRACK;
        end
        TRACK: begin
          if (one_bit) begin
            prev_gray <= sync2;
            bin_q     <= sample_bin;
            acc       <= sat ? base : acc_next;
          end else begin
            if (consume__ENA) begin
              acc <= '0;
            end
            if (multi) begin
              prev_gray <= sync2;
              bin_q     <= sample_bin;
            end
          end
        end
        default: state <= FILL0;
      endcase

      // a fresh error event outranks a simultaneous clear
      err_multi <= ev_multi | (err_multi & ~clearError__ENA);
      err_ovf   <= ev_ovf   | (err_ovf   & ~clearError__ENA);
    end
  end

  assign readBin         = bin_q;
  assign readDelta       = acc;
  assign readBin__RDY    = (state == TRACK);
  assign readDelta__RDY  = (state == TRACK);
  assign consume__RDY    = (state == TRACK);
  assign errorMulti      = err_multi;
  assign errorOvf        = err_ovf;
  assign clearError__RDY = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_gray_count_tracker.sv
`default_nettype none
// ============================================================================
// tb_gray_count_tracker : randomized scoreboard bench for gray_count_tracker.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_gray_count_tracker;

  localparam int W    = 4;
  localparam int M    = 1 << W;
  localparam int DMAX = (1 << (W - 1)) - 1;
  localparam int DMIN = -(1 << (W - 1));

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [W-1:0] grayIn = '0;
  logic         consume__ENA = 1'b0;
  logic         clearError__ENA = 1'b0;
  logic [W-1:0] readBin;
  logic         readBin__RDY;
  logic [W-1:0] readDelta;
  logic         readDelta__RDY;
  logic         consume__RDY;
  logic         errorMulti;
  logic         errorOvf;
  logic         clearError__RDY;

  gray_count_tracker #(.width(W)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .grayIn          (grayIn),
    .readBin         (readBin),
    .readBin__RDY    (readBin__RDY),
    .readDelta       (readDelta),
    .readDelta__RDY  (readDelta__RDY),
    .consume__ENA    (consume__ENA),
    .consume__RDY    (consume__RDY),
    .errorMulti      (errorMulti),
    .errorOvf        (errorOvf),
    .clearError__ENA (clearError__ENA),
    .clearError__RDY (clearError__RDY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int    due;
    int    bin;
    int    delta;
    int    multi;
    int    ovf;
    string tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   edges = 0;

  // reference state: value seen by the tracker and what it should report
  int m_bin   = 0;
  int m_delta = 0;
  int m_multi = 0;
  int m_ovf   = 0;

  always @(posedge CLK) edges <= edges + 1;

  function automatic logic [W-1:0] gray(input int v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // monitor: compares the DUT against the queued expectation once it is due
  always @(negedge CLK) begin
    exp_t e;
    while (q.size() > 0 && q[0].due < edges) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL %s_slot: actual=missed required=edge %0d", e.tag, e.due);
    end
    if (q.size() > 0 && q[0].due == edges) begin
      e = q.pop_front();
      check({e.tag, "_rdy"}, int'(readBin__RDY & readDelta__RDY & consume__RDY), 1);
      check({e.tag, "_bin"}, int'(readBin), e.bin);
      check({e.tag, "_delta"}, int'($signed(readDelta)), e.delta);
      check({e.tag, "_multi"}, int'(errorMulti), e.multi);
      check({e.tag, "_ovf"}, int'(errorOvf), e.ovf);
    end
  end

  task automatic model_apply(input int v, input bit cons, input bit clr);
    int hd;
    int step;
    int nd;
    bit ev_m;
    bit ev_o;
    ev_m = 1'b0;
    ev_o = 1'b0;
    hd = $countones(gray(v) ^ gray(m_bin));
    if (hd == 0) begin
      if (cons) m_delta = 0;
    end else if (hd == 1) begin
      step = (v == (m_bin + 1) % M) ? 1 : -1;
      nd = (cons ? 0 : m_delta) + step;
      if (nd > DMAX) begin nd = DMAX; ev_o = 1'b1; end
      if (nd < DMIN) begin nd = DMIN; ev_o = 1'b1; end
      m_delta = nd;
      m_bin   = v;
    end else begin
      ev_m  = 1'b1;
      m_bin = v;
      if (cons) m_delta = 0;
    end
    m_multi = clr ? int'(ev_m) : (m_multi | int'(ev_m));
    m_ovf   = clr ? int'(ev_o) : (m_ovf | int'(ev_o));
  endtask

  // one remote step: sample changes just after an edge, accepted three edges later
  task automatic xact(input int v, input bit cons, input bit clr, input string tag);
    exp_t e;
    int   old_bin;
    old_bin = m_bin;
    model_apply(v, cons, clr);
    e.due   = edges + 3;
    e.bin   = m_bin;
    e.delta = m_delta;
    e.multi = m_multi;
    e.ovf   = m_ovf;
    e.tag   = tag;
    q.push_back(e);
    grayIn = gray(v);
    repeat (2) @(posedge CLK);
    #1;
    check({tag, "_latency"}, int'(readBin), old_bin);
    consume__ENA    = cons;
    clearError__ENA = clr;
    @(posedge CLK);
    #1;
    consume__ENA    = 1'b0;
    clearError__ENA = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int v, input string tag);
    exp_t e;
    grayIn = gray(v);
    #2;
    nRST = 1'b0;
    #1;
    check({tag, "_rst_bin"}, int'(readBin), 0);
    check({tag, "_rst_delta"}, int'(readDelta), 0);
    check({tag, "_rst_multi"}, int'(errorMulti), 0);
    check({tag, "_rst_ovf"}, int'(errorOvf), 0);
    check({tag, "_rst_rdy"}, int'(readBin__RDY | readDelta__RDY | consume__RDY), 0);
    check({tag, "_rst_clrrdy"}, int'(clearError__RDY), 1);
    q.delete();
    repeat (2) @(posedge CLK);
    #1;
    nRST    = 1'b1;
    m_bin   = v;
    m_delta = 0;
    m_multi = 0;
    m_ovf   = 0;
    e.due   = edges + 3;
    e.bin   = v;
    e.delta = 0;
    e.multi = 0;
    e.ovf   = 0;
    e.tag   = {tag, "_prime"};
    q.push_back(e);
    repeat (2) @(posedge CLK);
    #1;
    check({tag, "_fill_rdy"}, int'(readBin__RDY | readDelta__RDY | consume__RDY), 0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(5, "init");

    xact(6, 1'b0, 1'b0, "up6");
    xact(7, 1'b0, 1'b0, "up7");
    xact(8, 1'b0, 1'b0, "up8");
    xact(8, 1'b1, 1'b0, "consume");

    for (int v = 9; v <= 15; v++) xact(v, 1'b0, 1'b0, "up_to15");
    xact(15, 1'b1, 1'b0, "consume15");
    xact(0, 1'b0, 1'b0, "wrap_up");
    xact(15, 1'b0, 1'b0, "wrap_dn");

    xact(0, 1'b0, 1'b0, "up0");
    xact(1, 1'b0, 1'b0, "up1");
    xact(2, 1'b0, 1'b0, "up2");
    xact(7, 1'b0, 1'b0, "jump");
    xact(7, 1'b0, 1'b1, "clr_multi");
    xact(2, 1'b0, 1'b1, "jump_with_clr");
    xact(2, 1'b1, 1'b1, "clr_consume");

    for (int v = 3; v <= 10; v++) xact(v, 1'b0, 1'b0, "sat_up");
    xact(9, 1'b1, 1'b0, "consume_dn");
    xact(9, 1'b0, 1'b1, "clr_ovf");

    xact(10, 1'b1, 1'b0, "pre_rst1");
    xact(11, 1'b0, 1'b0, "pre_rst2");
    do_reset(14, "midrun");

    for (int i = 0; i < 200; i++) begin
      int r;
      int v;
      r = int'($urandom_range(0, 9));
      if (r == 0)      v = int'($urandom_range(0, M - 1));
      else if (r < 6)  v = (m_bin + 1) % M;
      else if (r < 9)  v = (m_bin + M - 1) % M;
      else             v = m_bin;
      xact(v, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), "rand");
    end

    repeat (4) @(posedge CLK);
    #1;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
